// File: rtl/rx_line_pkg.sv
// Shared types and constants for the UART line assembler.
// Character defaults and the line-length width helper.
package rx_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_e;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] NUL = 8'h00;

  function automatic int len_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rx_line_assembler_edge.sv
// Rising-edge detector with configurable reset value.
// Holding the last sample high at reset masks a level already present.
module rx_edge_detect #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic last;

  always_ff @(posedge clock) begin
    if (reset) last <= RST_VAL;
    else       last <= level;
  end

  assign rise = level & ~last;

endmodule

// File: rtl/rx_line_assembler.sv
// Collects UART bytes into a line buffer in RAM.
// Handles backspace, an ignored char, overflow and NUL termination.
module rx_line_assembler
  import rx_line_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int MAX_LEN = 64,
  parameter logic [DATA_W-1:0] TERM_CHAR = DATA_W'(CR),
  parameter logic [DATA_W-1:0] BS_CHAR = DATA_W'(BS),
  parameter logic [DATA_W-1:0] IGN_CHAR = DATA_W'(LF),
  parameter logic [DATA_W-1:0] NUL_CHAR = DATA_W'(NUL)
) (
  input  logic clock,
  input  logic reset,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic rx_done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic write,
  output logic rx_line_done,
  output logic [len_w(MAX_LEN)-1:0] line_len,
  output logic overflow
);

  localparam int LW = len_w(MAX_LEN);
  localparam logic [LW-1:0] LAST = LW'(MAX_LEN - 1);
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN = RUN;

  logic [1:0] state;
  logic [LW-1:0] count;
  logic [ADDR_W-1:0] base;
  logic ovf_sticky;
  logic byte_evt;
  logic is_term, is_ign, is_bs;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] slot;

  rx_edge_detect #(.RST_VAL(1'b1)) u_edge (
    .clock(clock),
    .reset(reset),
    .level(rx_done),
    .rise(byte_evt)
  );

  assign is_term = (rx_data == TERM_CHAR);
  assign is_ign = (rx_data == IGN_CHAR);
  assign is_bs = (rx_data == BS_CHAR);

  // A line's first byte lands at start_addr before base is latched.
  assign cur_base = (state == ST_IDLE) ? start_addr : base;
  assign slot = cur_base + ADDR_W'(count);

  always_ff @(posedge clock) begin
    if (reset) begin
      addr <= '0;
      data <= '0;
      write <= 1'b0;
      rx_line_done <= 1'b0;
      line_len <= '0;
      overflow <= 1'b0;
      state <= ST_IDLE;
      count <= '0;
      base <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      write <= 1'b0;
      rx_line_done <= 1'b0;
      if (state != ST_IDLE && state != ST_RUN) begin
        state <= ST_IDLE;
        count <= '0;
      end else if (byte_evt) begin
        if (state == ST_IDLE) begin
          base <= start_addr;
          state <= ST_RUN;
        end
        unique case (1'b1)
          is_term: begin
            addr <= slot;
            data <= NUL_CHAR;
            write <= 1'b1;
            rx_line_done <= 1'b1;
            line_len <= count;
            overflow <= ovf_sticky;
            count <= '0;
            ovf_sticky <= 1'b0;
            state <= ST_IDLE;
          end
          is_ign: ;
          is_bs: begin
            if (count != '0) count <= count - 1'b1;
          end
          default: begin
            // Last slot stays reserved for the terminator.
            if (count < LAST) begin
              addr <= slot;
              data <= rx_data;
              write <= 1'b1;
              count <= count + 1'b1;
            end else begin
              ovf_sticky <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_line_assembler.sv
// Directed bench for rx_line_assembler.
// Drives two instances (MAX_LEN 64 and 4) from one byte stream.
module tb_rx_line_assembler;

  logic clock = 1'b0;
  logic reset;
  logic [7:0] start_addr;
  logic [7:0] rx_data;
  logic rx_done;

  logic [7:0] addr, data;
  logic write, rx_line_done, overflow;
  logic [5:0] line_len;

  logic [7:0] addr4, data4;
  logic write4, rx_line_done4, overflow4;
  logic [1:0] line_len4;

  int n_pass = 0;
  int n_tot = 0;
  int wcnt = 0;

  logic [7:0] s_a, s_d, t_a, t_d;
  logic s_w, s_ld, s_ov, t_w, t_ld, t_ov, s_wn;
  logic [31:0] s_len, t_len;

  always #5 clock = ~clock;

  rx_line_assembler dut (
    .clock(clock), .reset(reset),
    .start_addr(start_addr),
    .rx_data(rx_data), .rx_done(rx_done),
    .addr(addr), .data(data), .write(write),
    .rx_line_done(rx_line_done),
    .line_len(line_len), .overflow(overflow)
  );

  rx_line_assembler #(.MAX_LEN(4)) dut4 (
    .clock(clock), .reset(reset),
    .start_addr(start_addr),
    .rx_data(rx_data), .rx_done(rx_done),
    .addr(addr4), .data(data4), .write(write4),
    .rx_line_done(rx_line_done4),
    .line_len(line_len4), .overflow(overflow4)
  );

  always @(posedge clock) if (write) wcnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clock);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clock);
    #1;
    s_w = write; s_a = addr; s_d = data;
    s_ld = rx_line_done; s_ov = overflow;
    s_len = 32'(line_len);
    t_w = write4; t_a = addr4; t_d = data4;
    t_ld = rx_line_done4; t_ov = overflow4;
    t_len = 32'(line_len4);
    @(negedge clock);
    rx_done = 1'b0;
    @(posedge clock);
    #1;
    s_wn = write;
  endtask

  task automatic chk_wr(input string tag,
                        input logic [7:0] a,
                        input logic [7:0] d);
    chk({tag, "_w"}, 32'(s_w), 32'd1);
    chk({tag, "_a"}, 32'(s_a), 32'(a));
    chk({tag, "_d"}, 32'(s_d), 32'(d));
  endtask

  task automatic chk_wr4(input string tag,
                         input logic [7:0] a,
                         input logic [7:0] d);
    chk({tag, "_w4"}, 32'(t_w), 32'd1);
    chk({tag, "_a4"}, 32'(t_a), 32'(a));
    chk({tag, "_d4"}, 32'(t_d), 32'(d));
  endtask

  task automatic chk_end(input string tag,
                         input int len,
                         input logic ov);
    chk({tag, "_ld"}, 32'(s_ld), 32'd1);
    chk({tag, "_len"}, s_len, 32'(len));
    chk({tag, "_ov"}, 32'(s_ov), 32'(ov));
  endtask

  initial begin
    reset = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    start_addr = 8'h40;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_ld", 32'(rx_line_done), 32'h0);
    chk("rst_len", 32'(line_len), 32'h0);
    chk("rst_ov", 32'(overflow), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // "Hi" CR
    send("H"); chk_wr("hi_H", 8'h40, 8'h48);
    chk("hi_H_ld", 32'(s_ld), 32'd0);
    chk("hi_H_pulse", 32'(s_wn), 32'd0);
    send("i"); chk_wr("hi_i", 8'h41, 8'h69);
    send(8'h0D); chk_wr("hi_cr", 8'h42, 8'h00);
    chk_end("hi", 2, 1'b0);
    chk("hi_ld_pulse", 32'(rx_line_done), 32'd0);
    chk("hi_len4", t_len, 32'd2);

    // ab BS c LF CR
    send("a"); chk_wr("ed_a", 8'h40, 8'h61);
    send("b"); chk_wr("ed_b", 8'h41, 8'h62);
    send(8'h08); chk("ed_bs_w", 32'(s_w), 32'd0);
    send("c"); chk_wr("ed_c", 8'h41, 8'h63);
    send(8'h0A); chk("ed_lf_w", 32'(s_w), 32'd0);
    send(8'h0D); chk_wr("ed_cr", 8'h42, 8'h00);
    chk_end("ed", 2, 1'b0);

    // abcde CR: overflows only the short instance
    send("a"); chk_wr4("ov_a", 8'h40, 8'h61);
    send("b"); chk_wr4("ov_b", 8'h41, 8'h62);
    send("c"); chk_wr4("ov_c", 8'h42, 8'h63);
    send("d"); chk("ov_d_w4", 32'(t_w), 32'd0);
    chk_wr("ov_d", 8'h43, 8'h64);
    send("e"); chk("ov_e_w4", 32'(t_w), 32'd0);
    chk_wr("ov_e", 8'h44, 8'h65);
    send(8'h0D);
    chk_wr4("ov_cr", 8'h43, 8'h00);
    chk("ov_ld4", 32'(t_ld), 32'd1);
    chk("ov_len4", t_len, 32'd3);
    chk("ov_ov4", 32'(t_ov), 32'd1);
    chk_wr("ov_cr", 8'h45, 8'h00);
    chk_end("ov", 5, 1'b0);
    chk("ov_hold4", 32'(overflow4), 32'd1);

    send("k"); chk_wr4("cl_k", 8'h40, 8'h6B);
    send(8'h0D); chk_wr4("cl_cr", 8'h41, 8'h00);
    chk("cl_len4", t_len, 32'd1);
    chk("cl_ov4", 32'(t_ov), 32'd0);

    // wrap-around
    start_addr = 8'hFE;
    send("x"); chk_wr("wr_x", 8'hFE, 8'h78);
    start_addr = 8'h80;
    send("y"); chk_wr("wr_y", 8'hFF, 8'h79);
    send(8'h0D); chk_wr("wr_cr", 8'h00, 8'h00);
    chk_end("wr", 2, 1'b0);

    // rx_done held high through reset is not a byte
    @(negedge clock);
    reset = 1'b1;
    rx_data = "q";
    rx_done = 1'b1;
    start_addr = 8'h10;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wcnt = 0;
    repeat (10) @(posedge clock);
    #1;
    chk("held_wcnt", 32'(wcnt), 32'd0);
    @(negedge clock);
    rx_done = 1'b0;
    send(8'h0D); chk_wr("held_cr", 8'h10, 8'h00);
    chk_end("held", 0, 1'b0);

    // reset mid-line discards the partial line
    start_addr = 8'h30;
    send("a"); chk_wr("mr_a", 8'h30, 8'h61);
    send("b"); chk_wr("mr_b", 8'h31, 8'h62);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("mr_addr", 32'(addr), 32'h0);
    chk("mr_data", 32'(data), 32'h0);
    chk("mr_len", 32'(line_len), 32'h0);
    chk("mr_ld", 32'(rx_line_done), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    start_addr = 8'h20;
    send("z"); chk_wr("mr_z", 8'h20, 8'h7A);
    send(8'h0D); chk_wr("mr_cr", 8'h21, 8'h00);
    chk_end("mr", 1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
